// File: rtl/fas_frame_ctrl.sv
// fas_frame_ctrl: ping-pong frame buffer and scheduler that sits between a FIR
// sample stream and an FFT/analysis engine pair.
//
// Ports
//   clk        single clock, all state on rising edge
//   rst        asynchronous active-low reset
//   fir_valid  FIR sample present this cycle
//   fir_d      FIR sample (DW bits)
//   rd_addr    FFT engine read index into the current frame
//   rd_data    frame sample at rd_addr, combinational from the read buffer
//   fft_start  one-cycle pulse: a frame is ready for the FFT
//   fft_done   FFT engine finished the current frame
//   ana_start  one-cycle pulse: start peak/frequency analysis
//   ana_done   analysis finished
//   frame_cnt  number of frames fully processed
//   all_done   level: FRAMES frames processed
//   ovf        sticky: a sample was dropped
//   ovf_cnt    count of dropped samples, saturating at 255
//
// Optional feature: define FAS_OVF_CNT_EN to build the dropped-sample counter;
// without it ovf_cnt is tied to zero while ovf still works.

module fas_frame_ctrl #(
    parameter int unsigned FRAMES = 64,
    parameter int unsigned DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fir_valid,
    input  logic [DW-1:0] fir_d,
    input  logic [3:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          fft_start,
    input  logic          fft_done,
    output logic          ana_start,
    input  logic          ana_done,
    output logic [6:0]    frame_cnt,
    output logic          all_done,
    output logic          ovf,
    output logic [7:0]    ovf_cnt
);

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned FCNT_W  = 7;
    localparam int unsigned OCNT_W  = 8;

    localparam logic [FCNT_W-1:0] FRAMES_W = FCNT_W'(FRAMES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FFT_RUN,
        S_ANA_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic               wr_buf;
    logic               rd_buf;
    logic [IDX_W-1:0]   wr_idx;
    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic [DW-1:0]      frame_mem [2][DEPTH];

    logic               wr_en_c;
    logic               drop_c;
    logic               frame_end_c;
    logic               release_c;
    logic [FCNT_W-1:0]  frame_cnt_inc_c;

    // Sample acceptance: nothing is written or dropped once the run is complete.
    assign wr_en_c          = fir_valid && !full[wr_buf] && (state != S_DONE);
    assign drop_c           = fir_valid &&  full[wr_buf] && (state != S_DONE);
    assign frame_end_c      = wr_en_c && (wr_idx == LAST_IDX);
    assign release_c        = (state == S_FFT_RUN) && fft_done;
    assign frame_cnt_inc_c  = frame_cnt + FCNT_W'(1);

    // Set and clear can land in the same cycle; they always hit different buffers.
    always_comb begin
        full_nxt = full;
        if (release_c) begin
            full_nxt[rd_buf] = 1'b0;
        end
        if (frame_end_c) begin
            full_nxt[wr_buf] = 1'b1;
        end
    end

    // Frame storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            frame_mem[wr_buf][wr_idx] <= fir_d;
        end
    end

    // Writes never target rd_buf while a frame is being read, so this is stable in FFT_RUN.
    assign rd_data = frame_mem[rd_buf][rd_addr];

    // Write pointer, full flags, overflow flag and scheduler FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_buf    <= 1'b0;
            rd_buf    <= 1'b0;
            wr_idx    <= '0;
            full      <= '0;
            frame_cnt <= '0;
            fft_start <= 1'b0;
            ana_start <= 1'b0;
            all_done  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            fft_start <= 1'b0;
            ana_start <= 1'b0;
            full      <= full_nxt;

            if (wr_en_c) begin
                wr_idx <= wr_idx + IDX_W'(1);
                if (wr_idx == LAST_IDX) begin
                    wr_buf <= ~wr_buf;
                end
            end

            if (drop_c) begin
                ovf <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (full[rd_buf]) begin
                        fft_start <= 1'b1;
                        state     <= S_FFT_RUN;
                    end
                end
                S_FFT_RUN: begin
                    if (fft_done) begin
                        rd_buf    <= ~rd_buf;
                        ana_start <= 1'b1;
                        state     <= S_ANA_RUN;
                    end
                end
                S_ANA_RUN: begin
                    if (ana_done) begin
                        frame_cnt <= frame_cnt_inc_c;
                        if (frame_cnt_inc_c == FRAMES_W) begin
                            all_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state    <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    all_done <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FAS_OVF_CNT_EN
    logic [OCNT_W-1:0] ovf_cnt_q;

    // Dropped-sample counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_q <= '0;
        end else if (drop_c && (ovf_cnt_q != {OCNT_W{1'b1}})) begin
            ovf_cnt_q <= ovf_cnt_q + OCNT_W'(1);
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = OCNT_W'(0);
`endif

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// tb_fas_frame_ctrl: randomized scoreboard bench for fas_frame_ctrl.
// A frame-level reference model (accepted samples grouped into frames, at most
// two frames waiting) predicts frame contents, fft_start timing, ovf/ovf_cnt,
// frame_cnt and all_done. An engine process answers fft_start/ana_start and
// pops/compares the expected frames.

`timescale 1ns/1ns

module tb_fas_frame_ctrl;

    localparam int unsigned FRAMES = 64;
    localparam int unsigned DW     = 16;
    localparam int unsigned FBITS  = 16 * DW;

`ifdef FAS_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          fir_valid = 1'b0;
    logic [DW-1:0] fir_d     = '0;
    logic [3:0]    rd_addr   = '0;
    logic          fft_done  = 1'b0;
    logic          ana_done  = 1'b0;
    logic [DW-1:0] rd_data;
    logic          fft_start;
    logic          ana_start;
    logic [6:0]    frame_cnt;
    logic          all_done;
    logic          ovf;
    logic [7:0]    ovf_cnt;

    fas_frame_ctrl #(.FRAMES(FRAMES), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .ana_start (ana_start),
        .ana_done  (ana_done),
        .frame_cnt (frame_cnt),
        .all_done  (all_done),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              cyc      = 0;
    int              pending  = 0;
    int              part_n   = 0;
    int              m_frames = 0;
    int              m_drops  = 0;
    bit              m_ovf    = 1'b0;
    int              inc      = 0;
    logic [FBITS-1:0] part    = '0;
    logic [FBITS-1:0] exp_data[$];
    int              exp_cyc[$];

    // Engine-side state shared with the model
    bit fft_phase = 1'b0;
    bit ana_phase = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc      = 0;
            pending  = 0;
            part_n   = 0;
            m_frames = 0;
            m_drops  = 0;
            m_ovf    = 1'b0;
            exp_data.delete();
            exp_cyc.delete();
        end else begin
            cyc = cyc + 1;
            inc = 0;
            if (fir_valid && (m_frames != int'(FRAMES))) begin
                if (pending < 2) begin
                    part[part_n*DW +: DW] = fir_d;
                    part_n++;
                    if (part_n == 16) begin
                        exp_data.push_back(part);
                        exp_cyc.push_back(cyc);
                        part_n = 0;
                        inc    = 1;
                    end
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (fft_done && fft_phase) pending = pending - 1;
            pending = pending + inc;
            if (ana_done && ana_phase) m_frames++;
        end
    end

    // ---------------- engine + monitor ----------------
    int eng      = 0;
    int eng_now  = 0;
    int cnt      = 0;
    int n_fft    = 0;
    int n_ana    = 0;
    int idle_cyc = 0;
    int lat_mode = 0;
    int fft_lat  = 3;
    int ana_lat  = 3;
    int ec       = 0;
    logic [FBITS-1:0] fr;

    always begin
        @(negedge clk);
        if (!rst) begin
            fft_done  = 1'b0;
            ana_done  = 1'b0;
            rd_addr   = '0;
            eng       = 0;
            cnt       = 0;
            n_fft     = 0;
            n_ana     = 0;
            idle_cyc  = 0;
            fft_phase = 1'b0;
            ana_phase = 1'b0;
        end else begin
            fft_done = 1'b0;
            ana_done = 1'b0;
            eng_now  = eng;

            chk("frame_cnt", frame_cnt, m_frames);
            chk("all_done", all_done, (m_frames == int'(FRAMES)) ? 1 : 0);
            chk("ovf", ovf, m_ovf);
            chk("ovf_cnt", ovf_cnt, CNT_EN ? m_drops : 0);

            if (eng_now == 2) begin
                chk("ana_start_pulse", ana_start, 1);
                if (ana_start) n_ana++;
                fft_phase = 1'b0;
                ana_phase = 1'b1;
                cnt       = lat_mode ? int'($urandom_range(1, 8)) : ana_lat;
                eng       = 3;
            end else if (ana_start) begin
                chk("ana_start_spurious", 1, 0);
            end

            if (fft_start) begin
                if (eng_now != 0) begin
                    chk("fft_start_spurious", 1, 0);
                end else begin
                    n_fft++;
                    if (exp_data.size() == 0) begin
                        chk("fft_start_without_frame", 1, 0);
                    end else begin
                        fr = exp_data.pop_front();
                        ec = exp_cyc.pop_front();
                        chk("fft_start_cycle", cyc, ((ec > idle_cyc) ? ec : idle_cyc) + 1);
                        for (int i = 0; i < 16; i++) begin
                            rd_addr = 4'(i);
                            #1;
                            chk("rd_data", rd_data, fr[i*DW +: DW]);
                        end
                    end
                    fft_phase = 1'b1;
                    cnt       = lat_mode ? int'($urandom_range(1, 8)) : fft_lat;
                    eng       = 1;
                end
            end else begin
                case (eng_now)
                    0: if ($urandom_range(0, 7) == 0) fft_done = 1'b1;
                    1: begin
                        cnt--;
                        if (cnt <= 0) begin
                            fft_done = 1'b1;
                            eng      = 2;
                        end else if ($urandom_range(0, 2) == 0) begin
                            ana_done = 1'b1;
                        end
                    end
                    3: begin
                        cnt--;
                        if (cnt <= 0) begin
                            ana_done = 1'b1;
                            eng      = 4;
                        end else if ($urandom_range(0, 2) == 0) begin
                            fft_done = 1'b1;
                        end
                    end
                    4: begin
                        ana_phase = 1'b0;
                        idle_cyc  = cyc;
                        eng       = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic feed(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fir_valid = ($urandom_range(0, 99) < pct);
            fir_d     = DW'($urandom);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (!((int'(frame_cnt) >= n) && (eng == 0)) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk("wait_frame_cnt", frame_cnt, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fft_start"}, fft_start, 0);
        chk({tag, "_ana_start"}, ana_start, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_all_done"},  all_done,  0);
        chk({tag, "_ovf"},       ovf,       0);
        chk({tag, "_ovf_cnt"},   ovf_cnt,   0);
    endtask

    bit hit;
    int k;

    initial begin
        lat_mode = 0;
        fft_lat  = 3;
        ana_lat  = 3;

        // Power-on reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        #5 rst = 1'b1;

        // One ordered frame; fft_start must follow the 16th capture by one cycle
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            fir_valid = 1'b1;
            fir_d     = 16'h0100 + 16'(i);
        end
        @(negedge clk);
        fir_valid = 1'b0;
        chk("fft_start_early", fft_start, 0);
        @(negedge clk);
        chk("fft_start_rise", fft_start, 1);
        @(negedge clk);
        chk("fft_start_one_cycle", fft_start, 0);
        wait_frames(1, 200);

        // Overflow: FFT held off, 33rd sample is the first drop
        fft_lat = 300;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            fir_valid = 1'b1;
            fir_d     = DW'($urandom);
        end
        @(negedge clk);
        fir_valid = 1'b0;
        chk("ovf_first_drop", ovf, 1);
        chk("ovf_cnt_first_drop", ovf_cnt, CNT_EN ? 1 : 0);
        feed(267, 100);
        @(negedge clk);
        fir_valid = 1'b0;
        chk("ovf_cnt_saturated", ovf_cnt, CNT_EN ? 255 : 0);
        fft_lat = 3;
        wait_frames(3, 800);

        // Random traffic until frame 10 is done and the next FFT is in flight
        lat_mode = 1;
        hit      = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            fir_valid = ($urandom_range(0, 99) < 70);
            fir_d     = DW'($urandom);
            if ((int'(frame_cnt) >= 10) && (eng == 1) && (cnt >= 2)) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_fft_after_frame10", hit, 1);

        // Asynchronous reset mid-FFT
        #20;
        rst       = 1'b0;
        fir_valid = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        #5 rst = 1'b1;

        // Full run: 1024 back-to-back samples, engines answer after 3 cycles
        lat_mode = 0;
        fft_lat  = 3;
        ana_lat  = 3;
        feed(int'(FRAMES) * 16, 100);
        @(negedge clk);
        fir_valid = 1'b0;
        k = 0;
        while (!all_done && (k < 400)) begin
            @(negedge clk);
            k++;
        end
        chk("full_run_all_done", all_done, 1);
        chk("full_run_frame_cnt", frame_cnt, FRAMES);
        chk("full_run_ovf", ovf, 0);
        chk("full_run_fft_pulses", n_fft, FRAMES);
        chk("full_run_ana_pulses", n_ana, FRAMES);

        // Samples after completion are ignored
        feed(40, 100);
        @(negedge clk);
        fir_valid = 1'b0;
        @(negedge clk);
        chk("done_ovf", ovf, 0);
        chk("done_ovf_cnt", ovf_cnt, 0);
        chk("done_frame_cnt", frame_cnt, FRAMES);
        chk("done_all_done", all_done, 1);
        chk("done_no_new_frames", exp_data.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fas_frame_ctrl.md
FAS_FRAME_CTRL -- requirements
Module: fas_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAMES, default 64, meaning number of 16-sample frames per run (1024 samples).
REQ-002 SHALL have parameter DW, default 16, meaning FIR sample width (8 integer + 8 fraction).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port fir_valid, input, 1, a FIR sample is present this cycle.
REQ-006 SHALL have port fir_d, input, DW, FIR sample.
REQ-007 SHALL have port rd_addr, input, 4, FFT engine read index into the current frame.
REQ-008 SHALL have port rd_data, output, DW, frame sample at rd_addr, combinational from the buffer selected by rd_buf.
REQ-009 SHALL have port fft_start, output, 1, one-cycle pulse: frame ready for FFT.
REQ-010 SHALL have port fft_done, input, 1, FFT engine finished the current frame.
REQ-011 SHALL have port ana_start, output, 1, one-cycle pulse: start peak/frequency analysis.
REQ-012 SHALL have port ana_done, input, 1, analysis finished.
REQ-013 SHALL have port frame_cnt, output, 7, number of frames fully processed.
REQ-014 SHALL have port all_done, output, 1, level: FRAMES frames processed.
REQ-015 SHALL have port ovf, output, 1, sticky: a sample was dropped.
REQ-016 SHALL have port ovf_cnt, output, 8, count of dropped samples (see Configuration).

Function
REQ-017 SHALL hold two 16 x DW frame buffers (ping-pong), each with a full flag, a write pointer wr_buf/wr_idx and a read pointer rd_buf.
REQ-018 On fir_valid with full[wr_buf]=0 and state != DONE: SHALL write fir_d to buf[wr_buf][wr_idx] and increment wr_idx; at wr_idx=15, SHALL set full[wr_buf], toggle wr_buf and wrap wr_idx to 0.
REQ-019 On fir_valid with full[wr_buf]=1: SHALL drop the sample, leave wr_idx unchanged, set ovf and increment ovf_cnt (saturating at 255).
REQ-020 Scheduler FSM states: IDLE, FFT_RUN, ANA_RUN, DONE.
REQ-021 IDLE: if full[rd_buf]=1, SHALL pulse fft_start for one cycle and go to FFT_RUN; fft_start SHALL rise one cycle after the edge that captured the 16th sample, when the FSM is idle.
REQ-022 FFT_RUN: on fft_done, SHALL clear full[rd_buf], toggle rd_buf, pulse ana_start once and go to ANA_RUN.
REQ-023 ANA_RUN: on ana_done, SHALL increment frame_cnt; if the new value equals FRAMES, SHALL go to DONE, else go to IDLE.
REQ-024 DONE: SHALL hold all_done=1 and ignore fir_valid, fft_done and ana_done (no writes, no ovf) until reset.
REQ-025 fft_done outside FFT_RUN and ana_done outside ANA_RUN SHALL be ignored.
REQ-026 A set of full[wr_buf] and a clear of full[rd_buf] in the same cycle SHALL both take effect (different buffers by construction).
REQ-027 rd_data SHALL remain stable for the whole of FFT_RUN, since writes only target the other buffer.

Reset
REQ-028 rst low SHALL immediately clear the following, including mid-frame or mid-FFT: state=IDLE, wr_buf=rd_buf=0, wr_idx=0, full flags=0, frame_cnt=0, fft_start=0, ana_start=0, all_done=0, ovf=0, ovf_cnt=0.
REQ-029 Buffer contents need no reset; rd_data is don't-care until the first full frame.

Configuration
REQ-030 Macro FAS_OVF_CNT_EN: when defined, ovf_cnt SHALL count dropped samples per REQ-019; when undefined, ovf_cnt SHALL be tied to 0, no counter is built, and ovf still functions.

Verification
REQ-031 Reset, then 16 back-to-back fir_valid with fir_d=0x0100..0x010F -> fft_start pulses once one cycle after the 16th sample; rd_addr=5 gives rd_data=0x0105.
REQ-032 Continuous fir_valid with fft_done held off -> after 32 samples both buffers are full; the 33rd sample sets ovf=1 and ovf_cnt=1 (0 without FAS_OVF_CNT_EN); wr_idx is unchanged.
REQ-033 fft_done pulsed while in IDLE and ana_done pulsed in FFT_RUN -> no state change, no ana_start, frame_cnt unchanged.
REQ-034 1024 samples, with fft_done and ana_done each returned 3 cycles after their start pulse -> 64 fft_start and 64 ana_start pulses, frame_cnt=64, all_done=1, ovf=0; further fir_valid causes no ovf.
REQ-035 rst asserted in FFT_RUN after frame 10 -> all outputs return to their reset values asynchronously; a fresh 16-sample burst restarts from frame_cnt=0 with rd_buf=0.
